// File: rtl/i2c_arb_pkg.sv
// i2c_arb_pkg: shared state encoding, field widths and defaults for the i2c write arbiter
package i2c_arb_pkg;
  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_DONE, COMPLETE, DRAIN} arb_state_t;
  localparam int AW = 7;
  localparam int DW = 8;
  localparam int NREQ_DEF = 4;
  localparam int TIMEOUT_DEF = 4095;
endpackage

// File: rtl/i2c_rr_picker.sv
// i2c_rr_picker: combinational round-robin search for the first valid index at or after ptr
module i2c_rr_picker #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         valid,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [$clog2(NREQ)-1:0] grant_idx,
  output logic                    any
);
  localparam int IW = $clog2(NREQ);
  logic [2*NREQ-1:0] dbl;
  logic [IW-1:0] off;
  logic [IW:0] sum;
  // rotate so offset k of dbl is requester ptr+k, then wrap the sum back into range
  always_comb begin
    dbl = {valid, valid} >> ptr;
    off = '0;
    for (int k = NREQ - 1; k >= 0; k--) off = dbl[k] ? IW'(k) : off;
    sum = {1'b0, ptr} + {1'b0, off};
    grant_idx = (sum >= (IW+1)'(NREQ)) ? IW'(sum - (IW+1)'(NREQ)) : IW'(sum);
  end
  assign any = |valid;
endmodule

// File: rtl/i2c_write_arbiter.sv
// i2c_write_arbiter: round-robin arbitration of single-byte writes onto one i2c master with timeout
module i2c_write_arbiter import i2c_arb_pkg::*; #(
  parameter int NREQ = NREQ_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*AW-1:0]      req_addr,
  input  logic [NREQ*DW-1:0]      req_data,
  output logic [NREQ-1:0]         req_ack,
  output logic                    m_go,
  output logic [AW-1:0]           m_addr,
  output logic [DW-1:0]           m_data,
  input  logic                    m_busy,
  input  logic                    m_done,
  input  logic                    m_nack,
  output logic                    cpl_valid,
  output logic [$clog2(NREQ)-1:0] cpl_id,
  output logic                    cpl_err,
  output logic                    cpl_tmo,
  output logic                    busy
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT + 1);
  arb_state_t state;
  logic [IW-1:0] rr_ptr, gid, pick;
  logic [CW-1:0] cnt;
  logic any;
  logic tmo_hit;
  i2c_rr_picker #(.NREQ(NREQ)) u_pick (
    .valid(req_valid),
    .ptr(rr_ptr),
    .grant_idx(pick),
    .any(any)
  );
  // the counter reaches TIMEOUT on the same edge that enters COMPLETE
  assign tmo_hit = cnt == CW'(TIMEOUT - 1);
  assign busy = state != IDLE;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      rr_ptr <= '0;
      gid <= '0;
      cnt <= '0;
      req_ack <= '0;
      m_go <= 1'b0;
      m_addr <= '0;
      m_data <= '0;
      cpl_valid <= 1'b0;
      cpl_id <= '0;
      cpl_err <= 1'b0;
      cpl_tmo <= 1'b0;
    end else begin
      req_ack <= '0;
      cpl_valid <= 1'b0;
      case (state)
        IDLE: if (any) begin
          req_ack <= NREQ'(1) << pick;
          m_addr <= req_addr[int'(pick)*AW +: AW];
          m_data <= req_data[int'(pick)*DW +: DW];
          m_go <= 1'b1;
          gid <= pick;
          rr_ptr <= (pick == IW'(NREQ - 1)) ? '0 : pick + 1'b1;
          cnt <= '0;
          state <= LAUNCH;
        end
        LAUNCH, WAIT_DONE: begin
          cnt <= (cnt == CW'(TIMEOUT)) ? cnt : cnt + 1'b1;
          if (m_done || tmo_hit) begin
            m_go <= 1'b0;
            cpl_valid <= 1'b1;
            cpl_id <= gid;
            cpl_err <= m_done ? m_nack : 1'b1;
            cpl_tmo <= !m_done;
            state <= COMPLETE;
          end else if (state == LAUNCH && m_busy) begin
            m_go <= 1'b0;
            state <= WAIT_DONE;
          end
        end
        COMPLETE: begin
          cpl_err <= 1'b0;
          cpl_tmo <= 1'b0;
          state <= cpl_tmo ? DRAIN : IDLE;
        end
        DRAIN: if (!m_busy) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_i2c_write_arbiter.sv
// tb_i2c_write_arbiter: randomized self-checking bench with a round-robin reference model
module tb_i2c_write_arbiter;
  localparam int N = 4;
  logic clk = 1'b0, reset = 1'b1;
  logic [N-1:0] req_valid = '0, req_ack;
  logic [N*7-1:0] req_addr = '0;
  logic [N*8-1:0] req_data = '0;
  logic m_go, m_busy = 1'b0, m_done = 1'b0, m_nack = 1'b0;
  logic [6:0] m_addr;
  logic [7:0] m_data;
  logic cpl_valid, cpl_err, cpl_tmo, busy;
  logic [1:0] cpl_id;
  logic [N-1:0] t_req_valid = '0, t_req_ack;
  logic [N*7-1:0] t_req_addr = '0;
  logic [N*8-1:0] t_req_data = '0;
  logic t_m_go, t_m_busy = 1'b0, t_m_done = 1'b0, t_m_nack = 1'b0;
  logic [6:0] t_m_addr;
  logic [7:0] t_m_data;
  logic t_cpl_valid, t_cpl_err, t_cpl_tmo, t_busy;
  logic [1:0] t_cpl_id;
  int n_cmp = 0, n_bad = 0, mptr = 0;

  typedef struct {
    int ack_cnt, ack_cyc, gidx, cpl_cnt, cpl_cyc, cid, done_cyc;
    logic [6:0] a;
    logic [7:0] d;
    logic err, tmo, busy_after, go_bad, multi_ack;
  } obs_t;

  i2c_write_arbiter #(.NREQ(N), .TIMEOUT(4095)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ack(req_ack), .m_go(m_go), .m_addr(m_addr), .m_data(m_data), .m_busy(m_busy),
    .m_done(m_done), .m_nack(m_nack), .cpl_valid(cpl_valid), .cpl_id(cpl_id),
    .cpl_err(cpl_err), .cpl_tmo(cpl_tmo), .busy(busy)
  );

  i2c_write_arbiter #(.NREQ(N), .TIMEOUT(50)) dut_t (
    .clk(clk), .reset(reset), .req_valid(t_req_valid), .req_addr(t_req_addr), .req_data(t_req_data),
    .req_ack(t_req_ack), .m_go(t_m_go), .m_addr(t_m_addr), .m_data(t_m_data), .m_busy(t_m_busy),
    .m_done(t_m_done), .m_nack(t_m_nack), .cpl_valid(t_cpl_valid), .cpl_id(t_cpl_id),
    .cpl_err(t_cpl_err), .cpl_tmo(t_cpl_tmo), .busy(t_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1);
  end

  // reference: first valid requester at or after ptr, wrapping modulo N
  function automatic int rr_pick(input logic [N-1:0] v, input int ptr);
    int r = -1;
    for (int k = N - 1; k >= 0; k--) if (v[(ptr + k) % N]) r = (ptr + k) % N;
    return r;
  endfunction

  // i2c master model on the main DUT: raises busy lat cycles after m_go (lat=0: never),
  // holds it dur cycles, then pulses m_done; records what the arbiter shows each cycle
  task automatic xfer(input int lat, input int dur, input bit nack, input bit drop, output obs_t o);
    int go_cyc = -1, rel, gate, done_rel;
    o = '{default: 0};
    o.ack_cyc = -1; o.cpl_cyc = -1; o.done_cyc = -1;
    gate = lat > 0 ? lat : dur + 1;
    done_rel = lat > 0 ? lat - 1 + dur : dur;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (!$onehot0(req_ack)) o.multi_ack = 1'b1;
      if (req_ack != '0) begin
        o.ack_cnt++;
        if (o.ack_cyc < 0) begin
          o.ack_cyc = c; o.a = m_addr; o.d = m_data;
          for (int i = 0; i < N; i++) if (req_ack[i]) o.gidx = i;
        end
        if (drop) req_valid = req_valid & ~req_ack;
      end
      if (go_cyc < 0 && m_go) go_cyc = c;
      if (go_cyc >= 0 && o.cpl_cyc < 0 && m_go !== ((c - go_cyc) < gate)) o.go_bad = 1'b1;
      if (cpl_valid) begin
        o.cpl_cnt++;
        if (o.cpl_cyc < 0) begin o.cpl_cyc = c; o.cid = cpl_id; o.err = cpl_err; o.tmo = cpl_tmo; end
      end
      if (o.cpl_cyc >= 0 && c == o.cpl_cyc + 1) begin o.busy_after = busy; break; end
      if (go_cyc >= 0) begin
        rel = c - go_cyc;
        m_busy = lat > 0 && rel >= lat - 1 && rel < lat - 1 + dur;
        m_done = rel == done_rel;
        m_nack = nack && m_done;
        if (m_done) o.done_cyc = c;
      end
    end
    m_busy = 1'b0; m_done = 1'b0; m_nack = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    mptr = 0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++; if ({req_ack, m_go, m_addr, m_data, cpl_valid, cpl_id, cpl_err, cpl_tmo, busy} !== '0) begin
      n_bad++; $display("FAIL reset_outputs: got %h required 0", {req_ack, m_go, m_addr, m_data, cpl_valid, cpl_id, cpl_err, cpl_tmo, busy}); end
    n_cmp++; if ({t_req_ack, t_m_go, t_m_addr, t_m_data, t_cpl_valid, t_cpl_id, t_cpl_err, t_cpl_tmo, t_busy} !== '0) begin
      n_bad++; $display("FAIL reset_outputs_t: got %h required 0", {t_req_ack, t_m_go, t_m_addr, t_m_data, t_cpl_valid, t_cpl_id, t_cpl_err, t_cpl_tmo, t_busy}); end
    reset = 1'b0;
    mptr = 0;
  endtask

  task automatic test_single();
    obs_t o;
    req_valid = 4'b0001; req_addr[6:0] = 7'h51; req_data[7:0] = 8'h55;
    xfer(3, 200, 1'b0, 1'b1, o);
    n_cmp++; if (o.ack_cnt !== 1) begin n_bad++; $display("FAIL single_ack_count: got %0d required 1", o.ack_cnt); end
    n_cmp++; if (o.ack_cyc !== 0) begin n_bad++; $display("FAIL single_ack_latency: got %0d required 0", o.ack_cyc); end
    n_cmp++; if (o.gidx !== 0) begin n_bad++; $display("FAIL single_grant: got %0d required 0", o.gidx); end
    n_cmp++; if (o.a !== 7'h51) begin n_bad++; $display("FAIL single_addr: got %h required 51", o.a); end
    n_cmp++; if (o.d !== 8'h55) begin n_bad++; $display("FAIL single_data: got %h required 55", o.d); end
    n_cmp++; if (o.go_bad !== 1'b0) begin n_bad++; $display("FAIL single_go: got bad=%b required 0", o.go_bad); end
    n_cmp++; if (o.cpl_cnt !== 1) begin n_bad++; $display("FAIL single_cpl_count: got %0d required 1", o.cpl_cnt); end
    n_cmp++; if (o.cpl_cyc !== o.done_cyc + 1) begin n_bad++; $display("FAIL single_cpl_latency: got %0d required %0d", o.cpl_cyc, o.done_cyc + 1); end
    n_cmp++; if ({o.cid, o.err, o.tmo} !== {32'd0, 1'b0, 1'b0}) begin n_bad++; $display("FAIL single_cpl: got id=%0d err=%b tmo=%b required 0/0/0", o.cid, o.err, o.tmo); end
    n_cmp++; if (o.busy_after !== 1'b0) begin n_bad++; $display("FAIL single_idle_after: got busy=%b required 0", o.busy_after); end
    mptr = 1;
  endtask

  task automatic test_timeout();
    int ack_c = -1, cpl_c = -1, ack2 = -1;
    logic e = 1'b0, t = 1'b0, early = 1'b0, drain_busy = 1'b1;
    logic [1:0] id = '0;
    t_req_valid = 4'b0001;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (t_req_ack != '0 && ack_c < 0) begin ack_c = c; t_req_valid = 4'b0010; end
      if (t_cpl_valid && cpl_c < 0) begin cpl_c = c; e = t_cpl_err; t = t_cpl_tmo; id = t_cpl_id; end
      if (c > 0 && c < 84 && t_req_ack != '0) early = 1'b1;
      if (c >= 51 && c <= 82 && !t_busy) drain_busy = 1'b0;
      if (t_req_ack[1] && ack2 < 0) ack2 = c;
      t_m_busy = c >= 2 && c < 82;
      if (ack2 >= 0) break;
    end
    n_cmp++; if (ack_c !== 0) begin n_bad++; $display("FAIL tmo_ack: got %0d required 0", ack_c); end
    n_cmp++; if (cpl_c !== 50) begin n_bad++; $display("FAIL tmo_cycle: got %0d required 50", cpl_c); end
    n_cmp++; if ({e, t, id} !== {1'b1, 1'b1, 2'd0}) begin n_bad++; $display("FAIL tmo_flags: got err=%b tmo=%b id=%0d required 1/1/0", e, t, id); end
    n_cmp++; if (drain_busy !== 1'b1) begin n_bad++; $display("FAIL tmo_drain_busy: got %b required 1", drain_busy); end
    n_cmp++; if (early !== 1'b0) begin n_bad++; $display("FAIL tmo_no_grant_in_drain: got %b required 0", early); end
    n_cmp++; if (ack2 !== 84) begin n_bad++; $display("FAIL tmo_next_grant: got %0d required 84", ack2); end
    t_req_valid = '0; t_m_done = 1'b1;
    @(negedge clk);
    t_m_done = 1'b0;
    n_cmp++; if ({t_cpl_valid, t_cpl_id, t_cpl_err, t_cpl_tmo} !== {1'b1, 2'd1, 1'b0, 1'b0}) begin
      n_bad++; $display("FAIL launch_done_cpl: got %b required 1_01_0_0", {t_cpl_valid, t_cpl_id, t_cpl_err, t_cpl_tmo}); end
    @(negedge clk);
    n_cmp++; if (t_busy !== 1'b0) begin n_bad++; $display("FAIL launch_done_idle: got busy=%b required 0", t_busy); end
  endtask

  task automatic test_collision();
    int cpl_c = -1;
    logic e = 1'b0, t = 1'b1, after = 1'b1;
    logic [1:0] id = '0;
    t_req_valid = 4'b0100;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (t_req_ack != '0) t_req_valid = '0;
      if (t_cpl_valid && cpl_c < 0) begin cpl_c = c; e = t_cpl_err; t = t_cpl_tmo; id = t_cpl_id; end
      if (cpl_c >= 0 && c == cpl_c + 1) begin after = t_busy; break; end
      t_m_done = c == 49; t_m_nack = c == 49;
      t_m_busy = c >= 2 && c < 49;
    end
    t_m_done = 1'b0; t_m_nack = 1'b0; t_m_busy = 1'b0;
    n_cmp++; if (cpl_c !== 50) begin n_bad++; $display("FAIL coll_cycle: got %0d required 50", cpl_c); end
    n_cmp++; if ({e, t, id} !== {1'b1, 1'b0, 2'd2}) begin n_bad++; $display("FAIL coll_flags: got err=%b tmo=%b id=%0d required 1/0/2", e, t, id); end
    n_cmp++; if (after !== 1'b0) begin n_bad++; $display("FAIL coll_idle_after: got busy=%b required 0", after); end
  endtask

  task automatic test_fairness();
    obs_t o;
    int exp, prev = -1;
    apply_reset();
    for (int i = 0; i < N; i++) begin req_addr[7*i +: 7] = 7'($urandom); req_data[8*i +: 8] = 8'($urandom); end
    req_valid = '1;
    for (int t = 0; t < 6; t++) begin
      exp = rr_pick(req_valid, mptr);
      xfer($urandom_range(1, 4), $urandom_range(1, 30), 1'b0, 1'b0, o);
      n_cmp++; if (o.gidx !== exp) begin n_bad++; $display("FAIL fair_grant[%0d]: got %0d required %0d", t, o.gidx, exp); end
      n_cmp++; if ({o.a, o.d} !== {req_addr[7*exp +: 7], req_data[8*exp +: 8]}) begin
        n_bad++; $display("FAIL fair_payload[%0d]: got %h required %h", t, {o.a, o.d}, {req_addr[7*exp +: 7], req_data[8*exp +: 8]}); end
      n_cmp++; if (o.ack_cyc !== 0) begin n_bad++; $display("FAIL fair_turnaround[%0d]: got %0d required 0", t, o.ack_cyc); end
      if (t > 0) begin
        n_cmp++; if (o.gidx === prev) begin n_bad++; $display("FAIL fair_repeat[%0d]: got %0d required not %0d", t, o.gidx, prev); end
      end
      prev = o.gidx;
      mptr = (exp + 1) % N;
      req_addr[7*exp +: 7] = 7'($urandom); req_data[8*exp +: 8] = 8'($urandom);
    end
    req_valid = '0;
  endtask

  task automatic test_random();
    obs_t o;
    int exp;
    bit nk;
    for (int t = 0; t < 12; t++) begin
      for (int i = 0; i < N; i++) begin req_addr[7*i +: 7] = 7'($urandom); req_data[8*i +: 8] = 8'($urandom); end
      req_valid = 4'($urandom_range(1, 15));
      nk = 1'($urandom);
      exp = rr_pick(req_valid, mptr);
      xfer($urandom_range(0, 4), $urandom_range(1, 25), nk, 1'b0, o);
      n_cmp++; if (o.gidx !== exp) begin n_bad++; $display("FAIL rand_grant[%0d]: got %0d required %0d", t, o.gidx, exp); end
      n_cmp++; if ({o.a, o.d} !== {req_addr[7*exp +: 7], req_data[8*exp +: 8]}) begin
        n_bad++; $display("FAIL rand_payload[%0d]: got %h required %h", t, {o.a, o.d}, {req_addr[7*exp +: 7], req_data[8*exp +: 8]}); end
      n_cmp++; if ({o.cid, o.err, o.tmo} !== {exp, nk, 1'b0}) begin
        n_bad++; $display("FAIL rand_cpl[%0d]: got id=%0d err=%b tmo=%b required %0d/%b/0", t, o.cid, o.err, o.tmo, exp, nk); end
      n_cmp++; if ({o.ack_cnt, o.cpl_cnt} !== {32'd1, 32'd1}) begin
        n_bad++; $display("FAIL rand_pulses[%0d]: got ack=%0d cpl=%0d required 1/1", t, o.ack_cnt, o.cpl_cnt); end
      n_cmp++; if ({o.go_bad, o.multi_ack} !== 2'b00) begin
        n_bad++; $display("FAIL rand_go_ack[%0d]: got go_bad=%b multi=%b required 0/0", t, o.go_bad, o.multi_ack); end
      mptr = (exp + 1) % N;
    end
    req_valid = '0;
  endtask

  task automatic test_nack();
    obs_t o;
    req_valid = 4'b1000; req_addr[27:21] = 7'h33; req_data[31:24] = 8'hc4;
    xfer(2, 10, 1'b1, 1'b1, o);
    n_cmp++; if (o.gidx !== 3) begin n_bad++; $display("FAIL nack_grant: got %0d required 3", o.gidx); end
    n_cmp++; if ({o.err, o.tmo} !== 2'b10) begin n_bad++; $display("FAIL nack_flags: got err=%b tmo=%b required 1/0", o.err, o.tmo); end
    n_cmp++; if (o.cid !== 3) begin n_bad++; $display("FAIL nack_id: got %0d required 3", o.cid); end
    mptr = 0;
  endtask

  task automatic test_reset_mid();
    req_valid = 4'b0010; req_addr[13:7] = 7'h2a; req_data[15:8] = 8'h3c;
    @(negedge clk);
    m_busy = 1'b1;
    repeat (4) @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL mid_busy_before: got %b required 1", busy); end
    #2 reset = 1'b1;
    #1;
    n_cmp++; if ({req_ack, m_go, m_addr, m_data, cpl_valid, cpl_id, cpl_err, cpl_tmo, busy} !== '0) begin
      n_bad++; $display("FAIL mid_async_reset: got %h required 0", {req_ack, m_go, m_addr, m_data, cpl_valid, cpl_id, cpl_err, cpl_tmo, busy}); end
    req_valid = 4'b0110; m_busy = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (req_ack !== 4'b0010) begin n_bad++; $display("FAIL mid_first_grant: got %b required 0010", req_ack); end
    n_cmp++; if (cpl_valid !== 1'b0) begin n_bad++; $display("FAIL mid_no_cpl: got %b required 0", cpl_valid); end
    req_valid = '0; m_done = 1'b1;
    @(negedge clk);
    m_done = 1'b0;
    n_cmp++; if ({cpl_valid, cpl_id} !== {1'b1, 2'd1}) begin n_bad++; $display("FAIL mid_cpl: got %b required 1_01", {cpl_valid, cpl_id}); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_timeout();
    test_collision();
    test_fairness();
    test_random();
    test_nack();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
